mem_access_ctrl: RTL

Memory-stage access controller on the consuming side of the EXE/MEM pipeline register. Takes the registered memory-read and memory-write requests, address and store value. Performs each 32-bit access as two timed 16-bit transactions on an external asynchronous SRAM. Drives `ready` low for the whole access; upstream uses `freeze = ~ready` to hold every pipeline register until the access completes.

---
 rtl/mips_mem_pkg.sv | 14 +
 rtl/sram_wait_counter.sv | 31 +++
 rtl/mem_access_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the memory-stage SRAM access path.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } mem_state_e;

    localparam int SRAM_DW       = 16;
    localparam int DEF_ADDR_BASE = 1024;

endpackage

// File: rtl/sram_wait_counter.sv
// Phase wait counter: counts cycles inside one SRAM transaction.
// Latency: tc is combinational from the count; clear has priority over enable.
// Backpressure: none, the FSM decides when to clear and enable.
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: each 32-bit load/store becomes two timed 16-bit SRAM transactions.
// Latency: 2*WAIT_CYCLES+2 cycles per access including the request and DONE cycles.
// Backpressure: ready drops combinationally on a request and stays low until DONE.
module mem_access_ctrl
    import mips_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 5,
    parameter int ADDR_BASE   = DEF_ADDR_BASE,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        addr,
    input  logic [31:0]        st_val,
    output logic [31:0]        rd_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_o,
    input  logic [SRAM_DW-1:0] sram_dq_i,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               sram_ce_n
);

    localparam int WW = SRAM_AW - 1;

    mem_state_e state;
    logic          is_wr;
    logic [WW-1:0] word;
    logic [WW-1:0] word_d;
    logic [31:0]   st_q;
    logic          req;
    logic          active;
    logic          tc;

    assign req = mem_r_en | mem_w_en;

    // Addresses below ADDR_BASE wrap modulo the SRAM size; no range check.
    assign word_d = WW'((addr - 32'(ADDR_BASE)) >> 2);

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait (
        .clk (clk),
        .rst (rst),
        .clr ((state == IDLE) | tc),
        .en  (active),
        .tc  (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            is_wr   <= 1'b0;
            word    <= '0;
            st_q    <= '0;
            rd_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state <= LOW;
                        is_wr <= mem_w_en;
                        word  <= word_d;
                        st_q  <= st_val;
                    end
                end
                LOW: begin
                    if (tc) begin
                        state <= HIGH;
                        if (!is_wr) begin
                            rd_data[15:0] <= sram_dq_i;
                        end
                    end
                end
                HIGH: begin
                    if (tc) begin
                        state <= DONE;
                        if (!is_wr) begin
                            rd_data[31:16] <= sram_dq_i;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign active     = (state == LOW) | (state == HIGH);
    assign ready      = (state == DONE) | ((state == IDLE) & ~req);
    assign sram_addr  = {word, state == HIGH};
    assign sram_dq_o  = (state == HIGH) ? st_q[31:16] : st_q[15:0];
    assign sram_ce_n  = ~active;
    assign sram_we_n  = ~(active & is_wr);
    assign sram_dq_oe = active & is_wr;

endmodule
